// File: rtl/booth_mult_ctrl_if.sv
// rtl/booth_mult_ctrl_if.sv - host/datapath handshake bundle for the Booth multiplier sequencer
interface booth_mult_ctrl_if #(
  parameter int CNT_W = 3,
  parameter int OPC_W = 16
);
  logic             start;
  logic             abort;
  logic             res_ready;
  logic             start_rdy;
  logic             piso_load;
  logic             acc_clr;
  logic             acc_en;
  logic [CNT_W-1:0] digit_idx;
  logic             busy;
  logic             res_valid;
  logic             dp_clr;
  logic [OPC_W-1:0] op_cnt;

  modport master (
    output start, abort, res_ready,
    input  start_rdy, piso_load, acc_clr, acc_en, digit_idx,
    input  busy, res_valid, dp_clr, op_cnt
  );

  modport slave (
    input  start, abort, res_ready,
    output start_rdy, piso_load, acc_clr, acc_en, digit_idx,
    output busy, res_valid, dp_clr, op_cnt
  );
endinterface

// File: rtl/booth_mult_ctrl.sv
// rtl/booth_mult_ctrl.sv - sequencing FSM for the 8-bit radix-4 Booth multiplier
module booth_mult_ctrl #(
  parameter int N_DIGITS = 5,
  parameter int CNT_W    = 3,
  parameter int OPC_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  booth_mult_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N_DIGITS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] digit_q, digit_d;
  logic [OPC_W-1:0] op_cnt_q, op_cnt_d;
  logic             dp_clr_q, dp_clr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      digit_q  <= '0;
      op_cnt_q <= '0;
      dp_clr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      op_cnt_q <= op_cnt_d;
      dp_clr_q <= dp_clr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    op_cnt_d = op_cnt_q;
    dp_clr_d = 1'b0;
    // Abort only cancels real work; in IDLE it merely suppresses a same-cycle start.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      digit_d  = '0;
      dp_clr_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) state_d = S_LOAD;
        end
        S_LOAD: begin
          state_d = S_CALC;
          digit_d = '0;
        end
        S_CALC: begin
          if (digit_q == LAST_DIGIT) begin
            state_d = S_DONE;
            digit_d = '0;
          end else begin
            digit_d = digit_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            state_d  = S_IDLE;
            op_cnt_d = op_cnt_q + OPC_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.start_rdy = (state_q == S_IDLE);
    bus.piso_load = (state_q == S_LOAD);
    bus.acc_clr   = (state_q == S_LOAD);
    bus.acc_en    = (state_q == S_CALC);
    bus.busy      = (state_q == S_LOAD) || (state_q == S_CALC);
    bus.res_valid = (state_q == S_DONE);
    bus.dp_clr    = dp_clr_q;
    bus.digit_idx = digit_q;
    bus.op_cnt    = op_cnt_q;
  end
endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb/tb_booth_mult_ctrl.sv - self-checking bench for booth_mult_ctrl with a Booth datapath model
module tb_booth_mult_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   exp_ops = 0;

  always #5 clk = ~clk;

  booth_mult_ctrl_if #(.CNT_W(3), .OPC_W(16)) m ();
  booth_mult_ctrl #(.N_DIGITS(5), .CNT_W(3), .OPC_W(16)) dut (.clk(clk), .rst(rst), .bus(m));

  booth_mult_ctrl_if #(.CNT_W(3), .OPC_W(3)) w ();
  booth_mult_ctrl #(.N_DIGITS(5), .CNT_W(3), .OPC_W(3)) dut_w (.clk(clk), .rst(rst), .bus(w));

  // Datapath model steered only by the controller's strobes.
  logic [7:0] op_a = 8'd0;
  logic [7:0] op_b = 8'd0;
  logic [9:0] piso_m = 10'd0;
  logic       prev_m = 1'b0;
  int         acc_m = 0;

  always @(posedge clk) begin
    if (m.piso_load) begin
      piso_m <= {2'b00, op_b};
      prev_m <= 1'b0;
    end else begin
      piso_m <= piso_m >> 2;
      prev_m <= piso_m[1];
    end
    if (m.acc_clr) acc_m <= 0;
    else if (m.acc_en)
      acc_m <= acc_m + (int'(piso_m[0]) + int'(prev_m) - 2 * int'(piso_m[1]))
                       * int'(op_a) * (1 << (2 * int'(m.digit_idx)));
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({m.start_rdy, m.busy, m.res_valid, m.piso_load, m.acc_clr, m.acc_en, m.dp_clr} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=1000000",
               {m.start_rdy, m.busy, m.res_valid, m.piso_load, m.acc_clr, m.acc_en, m.dp_clr});
    end
    checks++;
    if (m.digit_idx !== 3'd0 || m.op_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters got idx=%0d ops=%0d exp 0/0", m.digit_idx, m.op_cnt);
    end
  endtask

  task automatic test_single_op();
    logic [15:0] prod;
    op_a = 8'hFF;
    op_b = 8'hFF;
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    checks++;
    if ({m.piso_load, m.acc_clr, m.busy, m.acc_en, m.start_rdy} !== 5'b11100) begin
      errors++;
      $display("FAIL single_load got=%b exp=11100", {m.piso_load, m.acc_clr, m.busy, m.acc_en, m.start_rdy});
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({m.acc_en, m.busy, m.piso_load, m.acc_clr, m.res_valid} !== 5'b11000 || m.digit_idx !== 3'(k)) begin
        errors++;
        $display("FAIL single_calc%0d got flags=%b idx=%0d exp 11000 idx=%0d",
                 k, {m.acc_en, m.busy, m.piso_load, m.acc_clr, m.res_valid}, m.digit_idx, k);
      end
    end
    tick();
    prod = acc_m[15:0];
    checks++;
    if ({m.res_valid, m.busy, m.acc_en} !== 3'b100 || prod !== 16'hFE01) begin
      errors++;
      $display("FAIL single_done got flags=%b prod=%h exp 100 prod=fe01", {m.res_valid, m.busy, m.acc_en}, prod);
    end
    m.res_ready = 1'b1;
    tick();
    m.res_ready = 1'b0;
    exp_ops++;
    checks++;
    if (m.start_rdy !== 1'b1 || m.res_valid !== 1'b0 || m.op_cnt !== 16'(exp_ops)) begin
      errors++;
      $display("FAIL single_ack got rdy=%b vld=%b ops=%0d exp 1/0/%0d", m.start_rdy, m.res_valid, m.op_cnt, exp_ops);
    end
  endtask

  task automatic test_hold();
    logic [15:0] want;
    op_a = 8'($urandom_range(0, 255));
    op_b = 8'($urandom_range(0, 255));
    want = op_a * op_b;
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    for (int k = 0; k < 10; k++) begin
      m.start = k[0];
      tick();
      checks++;
      if (m.res_valid !== 1'b1 || m.start_rdy !== 1'b0 || acc_m[15:0] !== want) begin
        errors++;
        $display("FAIL hold%0d got vld=%b rdy=%b prod=%h exp 1/0/%h", k, m.res_valid, m.start_rdy, acc_m[15:0], want);
      end
    end
    m.start = 1'b1;
    m.res_ready = 1'b1;
    tick();
    m.start = 1'b0;
    m.res_ready = 1'b0;
    exp_ops++;
    checks++;
    if (m.start_rdy !== 1'b1 || m.op_cnt !== 16'(exp_ops)) begin
      errors++;
      $display("FAIL hold_ack got rdy=%b ops=%0d exp 1/%0d", m.start_rdy, m.op_cnt, exp_ops);
    end
    tick();
    checks++;
    if (m.start_rdy !== 1'b1 || m.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_noqueue got rdy=%b busy=%b exp 1/0", m.start_rdy, m.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  av [3];
    logic [7:0]  bv [3];
    logic [15:0] want;
    int          n;
    av[0] = 8'd3;   bv[0] = 8'd5;
    av[1] = 8'd200; bv[1] = 8'd7;
    av[2] = 8'($urandom_range(0, 255)); bv[2] = 8'($urandom_range(0, 255));
    m.start = 1'b1;
    m.res_ready = 1'b1;
    for (int op = 0; op < 3; op++) begin
      op_a = av[op];
      op_b = bv[op];
      want = av[op] * bv[op];
      n = 0;
      while (!m.res_valid && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (m.res_valid !== 1'b1 || n !== 7 || acc_m[15:0] !== want) begin
        errors++;
        $display("FAIL b2b_op%0d got vld=%b cycles=%0d prod=%h exp 1/7/%h", op, m.res_valid, n, acc_m[15:0], want);
      end
      tick();
      exp_ops++;
      checks++;
      if (m.start_rdy !== 1'b1 || m.op_cnt !== 16'(exp_ops)) begin
        errors++;
        $display("FAIL b2b_ack%0d got rdy=%b ops=%0d exp 1/%0d", op, m.start_rdy, m.op_cnt, exp_ops);
      end
    end
    m.start = 1'b0;
    m.res_ready = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    op_a = 8'd77;
    op_b = 8'd91;
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (m.digit_idx !== 3'd2) begin
      errors++;
      $display("FAIL abort_pre got idx=%0d exp 2", m.digit_idx);
    end
    m.abort = 1'b1;
    tick();
    m.abort = 1'b0;
    checks++;
    if ({m.start_rdy, m.dp_clr, m.busy} !== 3'b110 || m.digit_idx !== 3'd0) begin
      errors++;
      $display("FAIL abort_calc got rdy/dpclr/busy=%b idx=%0d exp 110 idx=0", {m.start_rdy, m.dp_clr, m.busy}, m.digit_idx);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (m.dp_clr !== 1'b0 || m.res_valid !== 1'b0 || m.op_cnt !== 16'(exp_ops)) begin
        errors++;
        $display("FAIL abort_after%0d got dpclr=%b vld=%b ops=%0d exp 0/0/%0d", k, m.dp_clr, m.res_valid, m.op_cnt, exp_ops);
      end
    end
    m.abort = 1'b1;
    m.start = 1'b1;
    tick();
    m.abort = 1'b0;
    m.start = 1'b0;
    checks++;
    if (m.start_rdy !== 1'b1 || m.dp_clr !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got rdy=%b dpclr=%b exp 1/0", m.start_rdy, m.dp_clr);
    end
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    m.abort = 1'b1;
    m.res_ready = 1'b1;
    tick();
    m.abort = 1'b0;
    m.res_ready = 1'b0;
    checks++;
    if ({m.start_rdy, m.dp_clr, m.res_valid} !== 3'b110 || m.op_cnt !== 16'(exp_ops)) begin
      errors++;
      $display("FAIL abort_done got rdy/dpclr/vld=%b ops=%0d exp 110 ops=%0d", {m.start_rdy, m.dp_clr, m.res_valid}, m.op_cnt, exp_ops);
    end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] want;
    int          abort_at;
    int          hold;
    for (int it = 0; it < 20; it++) begin
      op_a = 8'($urandom_range(0, 255));
      op_b = 8'($urandom_range(0, 255));
      want = op_a * op_b;
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      hold = int'($urandom_range(0, 4));
      m.start = 1'b1;
      tick();
      m.start = 1'b0;
      if (abort_at != 0) begin
        for (int e = 1; e < abort_at; e++) tick();
        m.abort = 1'b1;
        tick();
        m.abort = 1'b0;
        checks++;
        if (m.dp_clr !== 1'b1 || m.start_rdy !== 1'b1 || m.op_cnt !== 16'(exp_ops)) begin
          errors++;
          $display("FAIL rnd%0d_abort@%0d got dpclr=%b rdy=%b ops=%0d exp 1/1/%0d",
                   it, abort_at, m.dp_clr, m.start_rdy, m.op_cnt, exp_ops);
        end
      end else begin
        for (int e = 2; e <= 6; e++) begin
          tick();
          checks++;
          if (m.acc_en !== 1'b1 || m.digit_idx !== 3'(e - 2)) begin
            errors++;
            $display("FAIL rnd%0d_digit got en=%b idx=%0d exp 1/%0d", it, m.acc_en, m.digit_idx, e - 2);
          end
        end
        tick();
        for (int h = 0; h <= hold; h++) begin
          checks++;
          if (m.res_valid !== 1'b1 || acc_m[15:0] !== want) begin
            errors++;
            $display("FAIL rnd%0d_prod got vld=%b prod=%h exp 1/%h (a=%0d b=%0d)",
                     it, m.res_valid, acc_m[15:0], want, op_a, op_b);
          end
          if (h < hold) tick();
        end
        m.res_ready = 1'b1;
        tick();
        m.res_ready = 1'b0;
        exp_ops++;
        checks++;
        if (m.start_rdy !== 1'b1 || m.op_cnt !== 16'(exp_ops)) begin
          errors++;
          $display("FAIL rnd%0d_ack got rdy=%b ops=%0d exp 1/%0d", it, m.start_rdy, m.op_cnt, exp_ops);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    int n;
    int want;
    w.start = 1'b1;
    w.res_ready = 1'b1;
    for (int op = 1; op <= 9; op++) begin
      n = 0;
      while (!w.res_valid && n < 20) begin
        tick();
        n++;
      end
      tick();
      want = op % 8;
      checks++;
      if (w.op_cnt !== 3'(want) || n >= 20) begin
        errors++;
        $display("FAIL wrap_op%0d got ops=%0d wait=%0d exp ops=%0d", op, w.op_cnt, n, want);
      end
    end
    w.start = 1'b0;
    w.res_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_ops = 0;
    checks++;
    if ({m.start_rdy, m.busy, m.res_valid, m.dp_clr} !== 4'b1000 || m.op_cnt !== 16'd0 || m.digit_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid got flags=%b ops=%0d idx=%0d exp 1000/0/0",
               {m.start_rdy, m.busy, m.res_valid, m.dp_clr}, m.op_cnt, m.digit_idx);
    end
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (m.res_valid !== 1'b0 || m.start_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_discard got vld=%b rdy=%b exp 0/1", m.res_valid, m.start_rdy);
    end
  endtask

  initial begin
    m.start = 1'b0;
    m.abort = 1'b0;
    m.res_ready = 1'b0;
    w.start = 1'b0;
    w.abort = 1'b0;
    w.res_ready = 1'b0;
    test_reset();
    test_single_op();
    test_hold();
    test_back_to_back();
    test_abort();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
